// File: rtl/piece_queue.sv
// Next-piece generator: an LCG feeds a shift-style preview FIFO in uniform or
// shuffled-bag mode; the head is popped with a valid/ready handshake.
module piece_queue #(
    parameter int PIECE_TYPES = 7,
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int STATE_W     = 18,
    parameter int SEED        = 8,
    parameter int MULT        = 1013,
    parameter int INC         = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic                         flush,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_piece,
    output logic [DEPTH*WIDTH-1:0]       preview,
    output logic [$clog2(DEPTH+1)-1:0]   preview_count,
    output logic [PIECE_TYPES-1:0]       bag_used
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(PIECE_TYPES);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    logic [0:0]             fsm_state;
    logic [0:0]             fsm_next;
    logic [STATE_W-1:0]     lcg_q;
    logic [STATE_W-1:0]     lcg_next;
    logic [WIDTH-1:0]       slot_q [DEPTH];
    logic [WIDTH-1:0]       slot_d [DEPTH];
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_after;
    logic [CW-1:0]          count_d;
    logic [PIECE_TYPES-1:0] bag_d;
    logic [PIECE_TYPES-1:0] bag_set;
    logic [7:0]             lcg_top;
    logic [7:0]             r_idx;
    logic [7:0]             pick;
    logic [PW:0]            idx;
    logic                   found;
    logic [WIDTH-1:0]       new_piece;
    logic                   pop;
    logic                   gen;

    // Handshake: the head transfers on any edge where out_valid && out_ready;
    // out_valid depends on registered state only, never on out_ready.
    assign out_valid     = (count_q != '0);
    assign pop           = out_valid & out_ready;
    assign gen           = !flush && ((fsm_state == S_FILL) || pop);
    assign out_piece     = slot_q[0];
    assign preview_count = count_q;

    always_comb begin
        preview = '0;
        for (int k = 0; k < DEPTH; k++) begin
            preview[k*WIDTH +: WIDTH] = slot_q[k];
        end
    end

    assign lcg_top  = lcg_q[STATE_W-1 -: 8];
    assign r_idx    = lcg_top % 8'(PIECE_TYPES);
    assign lcg_next = gen ? (lcg_q * STATE_W'(MULT) + STATE_W'(INC)) : lcg_q;

    // First unused id at or after r, wrapping; the bag is never full here
    // because it is emptied on the draw that would fill it.
    always_comb begin
        pick  = r_idx;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < PIECE_TYPES; k++) begin
            idx = (PW+1)'(r_idx) + (PW+1)'(k);
            if (idx >= (PW+1)'(PIECE_TYPES)) begin
                idx = idx - (PW+1)'(PIECE_TYPES);
            end
            if (!found && !bag_used[idx[PW-1:0]]) begin
                pick  = 8'(idx);
                found = 1'b1;
            end
        end
    end

    assign new_piece = WIDTH'(mode ? pick : r_idx);
    assign bag_set   = bag_used | (PIECE_TYPES'(1) << pick);

    always_comb begin
        if (flush || !mode) begin
            bag_d = '0;
        end else if (gen) begin
            bag_d = (&bag_set) ? '0 : bag_set;
        end else begin
            bag_d = bag_used;
        end
    end

    // Shift toward slot 0 on pop, then land the new piece in the first free slot.
    always_comb begin
        for (int k = 0; k < DEPTH - 1; k++) begin
            slot_d[k] = pop ? slot_q[k+1] : slot_q[k];
        end
        slot_d[DEPTH-1] = pop ? '0 : slot_q[DEPTH-1];
        count_after = count_q - CW'(pop);
        for (int k = 0; k < DEPTH; k++) begin
            if (gen && (count_after == CW'(k))) begin
                slot_d[k] = new_piece;
            end
        end
        count_d = count_after + CW'(gen);
    end

    always_comb begin
        fsm_next = fsm_state;
        if (flush) begin
            fsm_next = S_FILL;
        end else begin
            case (fsm_state)
                S_FILL:  if (count_d == CW'(DEPTH)) fsm_next = S_FULL;
                S_FULL:  if (pop && !gen) fsm_next = S_FILL;
                default: fsm_next = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcg_q     <= STATE_W'(SEED);
            fsm_state <= S_FILL;
            bag_used  <= '0;
            count_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            lcg_q     <= lcg_next;
            fsm_state <= fsm_next;
            bag_used  <= bag_d;
            if (flush) begin
                count_q <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    slot_q[k] <= '0;
                end
            end else begin
                count_q <= count_d;
                for (int k = 0; k < DEPTH; k++) begin
                    slot_q[k] <= slot_d[k];
                end
            end
        end
    end

endmodule
